// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch FIFO payload type for the fetch front end.
package fetch_pkg;

    localparam int unsigned DEFAULT_PC_W     = 8;
    localparam int unsigned DEFAULT_INSTR_W  = 16;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]    pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; pointers carry a wrap bit so full and empty are distinct.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output entry_t                   head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Flush wins over a same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && (count_o != '0)) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-deep in-flight tracking, prefetch FIFO to decode.
// Optional bubble counter output perf_bubbles is built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W       = DEFAULT_PC_W,
    parameter int unsigned INSTR_W    = DEFAULT_INSTR_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_bubbles
`endif
);

    localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    entry_t          head;
    entry_t          push_entry;
    logic            issue;
    logic            push;
    logic            pop;

    // The in-flight read already owns a FIFO slot, so a push never finds it full.
    assign occupancy  = count + CW'(inflight_q);
    assign issue      = rst_n && !redirect_valid && (occupancy < DEPTH_C);
    assign push       = inflight_q && !redirect_valid;
    assign pop        = id_valid && id_ready;
    assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign id_valid  = (count != '0);
    assign id_instr  = id_valid ? head.instr : '0;
    assign id_pc     = id_valid ? head.pc    : '0;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + PC_W'(1);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (id_ready && !id_valid && (perf_q != '1)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_bubbles = perf_q;
`endif

endmodule
